// File: rtl/reg_alloc_map_unit_pkg.sv
//==============================================================================
// Package : rau_pkg
// Shared FSM encoding and default geometry of the register allocation unit.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

package rau_pkg;

  localparam int NUM_WARPS_DEF     = 8;
  localparam int REGS_PER_WARP_DEF = 8;
  localparam int NUM_BANKS_DEF     = 4;
  localparam int NUM_ROWS_DEF      = 8;
  localparam int CHUNK_REGS_DEF    = 2;

  localparam int GROUPS = NUM_BANKS_DEF / CHUNK_REGS_DEF;
  localparam int SLOTS  = NUM_ROWS_DEF * GROUPS;
  localparam int CPW    = REGS_PER_WARP_DEF / CHUNK_REGS_DEF;

  typedef logic [1:0] rau_state_t;
  localparam rau_state_t ST_IDLE    = 2'd0;
  localparam rau_state_t ST_ALLOC   = 2'd1;
  localparam rau_state_t ST_DEALLOC = 2'd2;

endpackage

`default_nettype wire

// File: rtl/reg_alloc_map_unit_free_pick.sv
//==============================================================================
// Module : rau_free_pick
// Lowest-index free slot priority encoder with found flag.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module rau_free_pick #(
  parameter int SLOTS = 16
) (
  input  logic [SLOTS-1:0]         free_vec,
  output logic [$clog2(SLOTS)-1:0] idx,
  output logic                     found
);

  localparam int c_iw = $clog2(SLOTS);

  // Scan downwards so the last hit, the lowest index, wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        idx   = c_iw'(i);
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_alloc_map_unit.sv
//==============================================================================
// Module : reg_alloc_map_unit
// Allocates RF chunks to warps, frees them on exit, maps logical regs to bank/row.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module reg_alloc_map_unit
  import rau_pkg::*;
#(
  parameter int NUM_WARPS     = NUM_WARPS_DEF,
  parameter int REGS_PER_WARP = REGS_PER_WARP_DEF,
  parameter int NUM_BANKS     = NUM_BANKS_DEF,
  parameter int NUM_ROWS      = NUM_ROWS_DEF,
  parameter int CHUNK_REGS    = CHUNK_REGS_DEF,
  localparam int c_groups = NUM_BANKS / CHUNK_REGS,
  localparam int c_slots  = NUM_ROWS * c_groups,
  localparam int c_cpw    = REGS_PER_WARP / CHUNK_REGS,
  localparam int c_ww     = $clog2(NUM_WARPS),
  localparam int c_lw     = $clog2(REGS_PER_WARP),
  localparam int c_bw     = $clog2(NUM_BANKS),
  localparam int c_rw     = $clog2(NUM_ROWS),
  localparam int c_sw     = $clog2(c_slots),
  localparam int c_fw     = c_sw + 1,
  localparam int c_nw     = $clog2(c_cpw) + 1,
  localparam int c_ew     = (c_cpw > 1) ? $clog2(c_cpw) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_ready,
  input  logic [c_ww-1:0]      alloc_warp,
  input  logic [c_nw-1:0]      alloc_nchunks,
  input  logic [7:0]           alloc_sw_id,
  output logic                 alloc_done,
  output logic                 alloc_err,
  output logic [NUM_WARPS-1:0] alloc_stall,
  input  logic                 dealloc_req,
  output logic                 dealloc_ready,
  input  logic [c_ww-1:0]      dealloc_warp,
  output logic [c_fw-1:0]      free_chunks,
  input  logic [c_ww-1:0]      rd_warp,
  input  logic [c_lw-1:0]      src1_lreg,
  output logic [c_bw-1:0]      src1_bank,
  output logic [c_rw-1:0]      src1_row,
  output logic                 src1_map_ok,
  input  logic [c_lw-1:0]      src2_lreg,
  output logic [c_bw-1:0]      src2_bank,
  output logic [c_rw-1:0]      src2_row,
  output logic                 src2_map_ok,
  output logic [7:0]           rd_sw_id,
  input  logic [c_ww-1:0]      wr_warp,
  input  logic [c_lw-1:0]      wr_lreg,
  output logic [c_bw-1:0]      wr_bank,
  output logic [c_rw-1:0]      wr_row,
  output logic                 wr_map_ok
);

  rau_state_t         r_state;
  logic [c_slots-1:0] r_occ;
  logic [c_cpw-1:0]   r_lut_valid [NUM_WARPS];
  logic [c_sw-1:0]    r_lut_slot  [NUM_WARPS][c_cpw];
  logic [7:0]         r_sw_id     [NUM_WARPS];
  logic [c_ww-1:0]    r_warp;
  logic [c_nw-1:0]    r_count;
  logic [c_ew-1:0]    r_entry;
  logic [c_fw-1:0]    r_free;
  logic               r_done;
  logic               r_err;

  logic [c_sw-1:0]    w_pick;
  logic               w_found;
  logic               w_reject;
  logic               w_dvalid;
  logic [c_sw-1:0]    w_dslot;
  logic               w_last_alloc;
  logic               w_last_dealloc;
  logic [c_ew-1:0]    w_e1;
  logic [c_ew-1:0]    w_e2;
  logic [c_ew-1:0]    w_ew;

  rau_free_pick #(.SLOTS(c_slots)) u_free_pick (
    .free_vec (~r_occ),
    .idx      (w_pick),
    .found    (w_found)
  );

  assign alloc_ready   = (r_state == ST_IDLE) && !dealloc_req;
  assign dealloc_ready = (r_state == ST_IDLE);
  assign alloc_done    = r_done;
  assign alloc_err     = r_err;
  assign free_chunks   = r_free;

  // Checked before accepting so an allocation never ends up half done.
  assign w_reject = (int'(alloc_nchunks) > int'(r_free)) ||
                    (int'(alloc_nchunks) > c_cpw) ||
                    (|r_lut_valid[alloc_warp]);

  assign w_dvalid       = r_lut_valid[r_warp][r_entry];
  assign w_dslot        = r_lut_slot[r_warp][r_entry];
  assign w_last_alloc   = (int'(r_entry) + 1 == int'(r_count));
  assign w_last_dealloc = (int'(r_entry) == c_cpw - 1);

  always_comb begin
    alloc_stall = '0;
    if (r_state == ST_ALLOC) alloc_stall[r_warp] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_occ   <= '0;
      r_warp  <= '0;
      r_count <= '0;
      r_entry <= '0;
      r_free  <= c_fw'(c_slots);
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_lut_valid[w] <= '0;
        r_sw_id[w]     <= '0;
        for (int e = 0; e < c_cpw; e++) r_lut_slot[w][e] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dealloc_req) begin
            r_warp  <= dealloc_warp;
            r_entry <= '0;
            r_state <= ST_DEALLOC;
          end else if (alloc_req) begin
            if (w_reject) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_sw_id[alloc_warp] <= alloc_sw_id;
              if (alloc_nchunks == '0) begin
                r_done <= 1'b1;
              end else begin
                r_warp  <= alloc_warp;
                r_count <= alloc_nchunks;
                r_entry <= '0;
                r_state <= ST_ALLOC;
              end
            end
          end
        end
        ST_ALLOC: begin
          if (w_found) begin
            r_lut_valid[r_warp][r_entry] <= 1'b1;
            r_lut_slot[r_warp][r_entry]  <= w_pick;
            r_occ[w_pick]                <= 1'b1;
            r_free                       <= r_free - 1'b1;
            if (w_last_alloc) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_entry <= r_entry + 1'b1;
            end
          end else begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_DEALLOC: begin
          if (w_dvalid) begin
            r_lut_valid[r_warp][r_entry] <= 1'b0;
            r_occ[w_dslot]               <= 1'b0;
            r_free                       <= r_free + 1'b1;
          end
          if (w_last_dealloc) r_state <= ST_IDLE;
          else                r_entry <= r_entry + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  function automatic logic [c_bw+c_rw:0] f_map(input logic            valid,
                                               input logic [c_sw-1:0] slot,
                                               input logic [c_lw-1:0] lreg);
    logic [c_bw-1:0] bank;
    logic [c_rw-1:0] row;
    bank = '0;
    row  = '0;
    if (valid) begin
      row  = c_rw'(int'(slot) / c_groups);
      bank = c_bw'((int'(slot) % c_groups) * CHUNK_REGS + int'(lreg) % CHUNK_REGS);
    end
    return {valid, bank, row};
  endfunction

  assign w_e1 = c_ew'(int'(src1_lreg) / CHUNK_REGS);
  assign w_e2 = c_ew'(int'(src2_lreg) / CHUNK_REGS);
  assign w_ew = c_ew'(int'(wr_lreg) / CHUNK_REGS);

  assign {src1_map_ok, src1_bank, src1_row} =
    f_map(r_lut_valid[rd_warp][w_e1], r_lut_slot[rd_warp][w_e1], src1_lreg);
  assign {src2_map_ok, src2_bank, src2_row} =
    f_map(r_lut_valid[rd_warp][w_e2], r_lut_slot[rd_warp][w_e2], src2_lreg);
  assign {wr_map_ok, wr_bank, wr_row} =
    f_map(r_lut_valid[wr_warp][w_ew], r_lut_slot[wr_warp][w_ew], wr_lreg);

  assign rd_sw_id = r_sw_id[rd_warp];

endmodule

`default_nettype wire

// File: tb/tb_reg_alloc_map_unit.sv
//==============================================================================
// Module : tb_reg_alloc_map_unit
// Randomised bench for reg_alloc_map_unit against a transaction-level model.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module tb_reg_alloc_map_unit;
  import rau_pkg::*;

  localparam int CH = 2;

  logic       clk;
  logic       rst;
  logic       alloc_req, alloc_ready, alloc_done, alloc_err;
  logic [2:0] alloc_warp, alloc_nchunks;
  logic [7:0] alloc_sw_id, alloc_stall, rd_sw_id;
  logic       dealloc_req, dealloc_ready;
  logic [2:0] dealloc_warp;
  logic [4:0] free_chunks;
  logic [2:0] rd_warp, src1_lreg, src2_lreg, wr_warp, wr_lreg;
  logic [1:0] src1_bank, src2_bank, wr_bank;
  logic [2:0] src1_row, src2_row, wr_row;
  logic       src1_map_ok, src2_map_ok, wr_map_ok;

  reg_alloc_map_unit dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_warp(alloc_warp),
    .alloc_nchunks(alloc_nchunks), .alloc_sw_id(alloc_sw_id), .alloc_done(alloc_done),
    .alloc_err(alloc_err), .alloc_stall(alloc_stall),
    .dealloc_req(dealloc_req), .dealloc_ready(dealloc_ready), .dealloc_warp(dealloc_warp),
    .free_chunks(free_chunks), .rd_warp(rd_warp),
    .src1_lreg(src1_lreg), .src1_bank(src1_bank), .src1_row(src1_row), .src1_map_ok(src1_map_ok),
    .src2_lreg(src2_lreg), .src2_bank(src2_bank), .src2_row(src2_row), .src2_map_ok(src2_map_ok),
    .rd_sw_id(rd_sw_id), .wr_warp(wr_warp), .wr_lreg(wr_lreg),
    .wr_bank(wr_bank), .wr_row(wr_row), .wr_map_ok(wr_map_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which slot each (warp, entry) holds, which slots are taken, etc.
  bit       m_valid [8][4];
  int       m_slot  [8][4];
  bit       m_occ   [16];
  int       m_free;
  int       m_sw    [8];
  bit       m_idle, m_done, m_err;
  int       m_stall;
  logic [1:0] last_de;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 8; w++) begin
      m_sw[w] = 0;
      for (int e = 0; e < 4; e++) begin m_valid[w][e] = 0; m_slot[w][e] = 0; end
    end
    for (int s = 0; s < 16; s++) m_occ[s] = 0;
    m_free = SLOTS; m_idle = 1; m_done = 0; m_err = 0; m_stall = 0;
  endtask

  function automatic int emap(input int w, input int l);
    int e, s;
    e = l / CH;
    if (!m_valid[w][e]) return 0;
    s = m_slot[w][e];
    return (1 << 5) | ((((s % GROUPS) * CH) + (l % CH)) << 3) | (s / GROUPS);
  endfunction

  function automatic bit live(input int w);
    for (int e = 0; e < 4; e++) if (m_valid[w][e]) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    check("done", alloc_done, m_done);
    check("err", alloc_err, m_err);
    check("stall", alloc_stall, m_stall);
    check("free", free_chunks, m_free);
    check("alloc_ready", alloc_ready, m_idle && !dealloc_req);
    check("dealloc_ready", dealloc_ready, m_idle);
    check("rd_sw_id", rd_sw_id, m_sw[rd_warp]);
    check("src1_map", {src1_map_ok, src1_bank, src1_row}, emap(rd_warp, src1_lreg));
    check("src2_map", {src2_map_ok, src2_bank, src2_row}, emap(rd_warp, src2_lreg));
    check("wr_map", {wr_map_ok, wr_bank, wr_row}, emap(wr_warp, wr_lreg));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rd_warp   = 3'($urandom_range(0, 7));
    src1_lreg = 3'($urandom_range(0, 7));
    src2_lreg = 3'($urandom_range(0, 7));
    wr_warp   = 3'($urandom_range(0, 7));
    wr_lreg   = 3'($urandom_range(0, 7));
  endtask

  task automatic do_alloc(input int w, input int n, input int sw);
    bit rej;
    int s;
    alloc_req = 1; alloc_warp = 3'(w); alloc_nchunks = 3'(n); alloc_sw_id = 8'(sw);
    rej = (n > m_free) || (n > CPW) || live(w);
    tick();
    alloc_req = 0;
    if (rej || n == 0) begin
      if (!rej) m_sw[w] = sw;
      m_done = 1; m_err = rej;
      #1 last_de = {alloc_done, alloc_err};
      tick();
      m_done = 0; m_err = 0;
      return;
    end
    m_sw[w] = sw; m_idle = 0; m_stall = 1 << w;
    for (int k = 0; k < n; k++) begin
      tick();
      s = 0;
      while (m_occ[s]) s++;
      m_valid[w][k] = 1; m_slot[w][k] = s; m_occ[s] = 1; m_free--;
      if (k == n - 1) begin
        m_done = 1; m_stall = 0; m_idle = 1;
        #1 last_de = {alloc_done, alloc_err};
      end
    end
    tick();
    m_done = 0;
  endtask

  task automatic do_dealloc(input int w);
    dealloc_req = 1; dealloc_warp = 3'(w);
    tick();
    dealloc_req = 0; m_idle = 0;
    for (int e = 0; e < CPW; e++) begin
      tick();
      if (m_valid[w][e]) begin
        m_valid[w][e] = 0; m_occ[m_slot[w][e]] = 0; m_free++;
      end
      if (e == CPW - 1) m_idle = 1;
    end
  endtask

  task automatic apply_reset();
    rst = 0; model_reset();
    tick(); tick();
    rst = 1;
    tick();
  endtask

  initial begin
    alloc_req = 0; alloc_warp = 0; alloc_nchunks = 0; alloc_sw_id = 0;
    dealloc_req = 0; dealloc_warp = 0;
    rd_warp = 0; src1_lreg = 0; src2_lreg = 0; wr_warp = 0; wr_lreg = 0;
    last_de = 0;
    model_reset();
    rst = 0;
    tick(); tick();
    check("reset_free", free_chunks, 16);
    rst = 1;
    tick();

    // Scenario 1: warp 3 gets three chunks in slots 0..2.
    do_alloc(3, 3, 8'hA3);
    check("t1_done_noerr", last_de, 2'b10);
    check("t1_free", free_chunks, 13);
    rd_warp = 3; src1_lreg = 3; src2_lreg = 4; #1;
    check("t1_lreg3", {src1_map_ok, src1_bank, src1_row}, 6'b1_11_000);
    check("t1_lreg4", {src2_map_ok, src2_bank, src2_row}, 6'b1_00_001);
    check("t1_swid", rd_sw_id, 8'hA3);

    // Scenario 2: freed chunks are reused lowest first.
    apply_reset();
    do_alloc(0, 4, 1); do_alloc(1, 4, 2);
    do_dealloc(0);
    do_alloc(2, 2, 3);
    check("t2_free", free_chunks, 10);
    rd_warp = 2; src1_lreg = 0; src2_lreg = 3; #1;
    check("t2_slot0", {src1_map_ok, src1_bank, src1_row}, 6'b1_00_000);
    check("t2_slot1", {src2_map_ok, src2_bank, src2_row}, 6'b1_11_000);

    // Scenario 3: pool of 2 cannot satisfy 3.
    apply_reset();
    do_alloc(5, 5, 9);
    check("t3_over_cpw", last_de, 2'b11);
    do_alloc(0, 4, 1); do_alloc(1, 4, 1); do_alloc(2, 4, 1); do_alloc(3, 2, 1);
    check("t3_free2", free_chunks, 2);
    do_alloc(4, 3, 7);
    check("t3_err", last_de, 2'b11);
    check("t3_free_kept", free_chunks, 2);
    wr_warp = 4; wr_lreg = 0; #1;
    check("t3_nomap", {wr_map_ok, wr_bank, wr_row}, 0);

    // Scenario 4: simultaneous requests, dealloc first then alloc.
    alloc_req = 1; alloc_warp = 3'd6; alloc_nchunks = 3'd2; alloc_sw_id = 8'h66;
    do_dealloc(1);
    do_alloc(6, 2, 8'h66);
    check("t4_free", free_chunks, 4);

    // Scenario 6: live-warp realloc rejected; zero-chunk alloc succeeds.
    do_alloc(6, 1, 0);
    check("t6_live_err", last_de, 2'b11);
    do_alloc(7, 0, 8'h77);
    check("t6_zero_ok", last_de, 2'b10);
    rd_warp = 7; src1_lreg = 5; #1;
    check("t6_unalloc", {src1_map_ok, src1_bank, src1_row}, 0);

    // Scenario 5: reset in the middle of an allocation.
    apply_reset();
    alloc_req = 1; alloc_warp = 3'd4; alloc_nchunks = 3'd4; alloc_sw_id = 8'h44;
    tick();
    alloc_req = 0; m_sw[4] = 8'h44; m_idle = 0; m_stall = 1 << 4;
    tick(); m_valid[4][0] = 1; m_slot[4][0] = 0; m_occ[0] = 1; m_free--;
    tick(); m_valid[4][1] = 1; m_slot[4][1] = 1; m_occ[1] = 1; m_free--;
    rst = 0; model_reset(); #1;
    check("t5_free", free_chunks, 16);
    check("t5_stall", alloc_stall, 0);
    tick(); tick();
    rst = 1;
    tick();

    // Randomised traffic.
    for (int i = 0; i < 120; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 3) begin
        do_dealloc($urandom_range(0, 7));
      end else if (op == 3) begin
        int w, n, sw;
        w = $urandom_range(0, 7); n = $urandom_range(0, 5); sw = $urandom_range(0, 255);
        alloc_req = 1; alloc_warp = 3'(w); alloc_nchunks = 3'(n); alloc_sw_id = 8'(sw);
        do_dealloc($urandom_range(0, 7));
        do_alloc(w, n, sw);
      end else begin
        do_alloc($urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 255));
      end
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
